uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  Serial receiver, the stage directly downstream of uart_tx; consumes the line driven on txd.
//  Oversamples rxd at 16x baud and deframes start/data/parity/stop.
//  Presents one character with its status flags to the 16550 RBR/LSR logic.
//  Flags: parity, framing, break, overrun.
// PARAMETERS
//  OVERSAMPLE   16  ticks per bit; mid-bit sample taken at count OVERSAMPLE/2-1 (=7)
//  SYNC_STAGES  2   flip-flops in the rxd synchronizer
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  reset, asynchronous assert, active-low
//  rxd          in   1  serial line, idle high, asynchronous to clk
//  tick_16x     in   1  one-clk pulse at 16x baud from the baud generator
//  enable_baud  out  1  requests tick_16x; baud gen restarts phase on rise
//  data_bits    in   4  5..8 data bits (values <5 treated as 5, >8 as 8)
//  parity_en    in   1  parity bit present
//  parity_even  in   1  1=even, 0=odd
//  rx_data      out  8  received char, LSB first, zero above data_bits
//  rx_valid     out  1  level; char held in rx_data, cleared by rx_read
//  rx_read      in   1  one-clk pulse: consumer took rx_data; clears rx_valid and flags
//  parity_err   out  1  parity mismatch for the char in rx_data
//  framing_err  out  1  first stop bit sampled 0
//  break_det    out  1  data, parity and stop all sampled 0
//  overrun_err  out  1  a frame completed while rx_valid=1; new frame discarded
//  rx_busy      out  1  state != IDLE
// BEHAVIOUR
//  Reset: rx_data=0; rx_valid, all error flags, rx_busy, enable_baud=0; state IDLE.
//    Synchronizer flops reset to 1.
//  Reset mid-frame aborts immediately; no partial char is delivered.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; BRK_WAIT after a break.
//  IDLE: synced rxd 1->0 edge -> START next clk.
//    Same edge: tick cnt=0, enable_baud=1.
//    Same edge: data_bits/parity_en/parity_even latched for the whole frame.
//  Bit timing: tick cnt increments per tick_16x; sample when cnt==7.
//    After the sample, wait until cnt==15, then wrap to 0 for the next bit.
//  START: sample 1 = false start (glitch) -> IDLE, no flags, enable_baud=0.
//    Sample 0 -> DATA.
//  DATA: shift in LSB first; bit index 0..data_bits-1.
//    Last data bit -> PARITY if parity_en, else STOP.
//  PARITY: even mode error if XOR(data,parity_bit)=1; odd mode error if it is 0.
//  STOP: only the first stop bit is checked (2-stop frames accepted).
//    The receiver resyncs on the next edge.
//  Completion happens on the clk after the stop sample.
//    If rx_valid=0, or rx_read is asserted the same clk:
//      rx_data, parity_err, framing_err and break_det load; rx_valid=1.
//    Else: rx_data/flags unchanged; overrun_err=1 (sticky until rx_read).
//  Break (all samples 0): break_det=1; rx_data=0.
//    Go to BRK_WAIT until synced rxd=1, then IDLE.
//    Prevents repeated frames from one held-low line.
//  STOP sampled 1 -> IDLE; enable_baud drops the clk after completion.
//  rx_read with rx_valid=0: no effect except clearing overrun_err.
//  rxd input-to-state latency: SYNC_STAGES clks.
// STRUCTURE
//  uart_pkg: rx_state_t enum {IDLE,START,DATA,PARITY,STOP,BRK_WAIT}; OVERSAMPLE_DFLT=16.
//  uart_pkg: DATA_BITS_MIN=5, DATA_BITS_MAX=8.
//  Sub-module uart_rx_sync: SYNC_STAGES flop chain on rxd, reset-to-1, plus fall-edge pulse.
//  Counters: tick cnt 4b, bit idx 3b; shift reg 8b.
// TESTING (loopback: uart_tx txd -> rxd, shared baud gen; 1x tick = every 16th tick_16x)
//  1) 0xA5, 8N1 -> rx_valid=1, rx_data=A5, all error flags 0.
//  2) 0x3C 8E1 and 0x55 8O1 -> correct data, parity_err=0.
//     Forced bad parity bit on 0x3C -> parity_err=1, rx_data=3C.
//  3) 0x6B 7E2 -> rx_data=6B; 0x1B 5O2 -> rx_data=1B.
//     0x0F 6N1 -> rx_data=0F (upper bits zero).
//  4) Glitch: rxd low for 5 tick_16x -> no rx_valid, rx_busy back to 0.
//     Stop bit forced 0 on 0xA5 -> framing_err=1.
//  5) Two frames 0x11, 0x22 with no rx_read -> rx_data=11, overrun_err=1.
//     rx_read -> all clear; third frame 0x33 -> rx_data=33, overrun_err=0.
//  6) rxd held low 20 bit times -> one char, rx_data=00, break_det=1, framing_err=1.
//     No second rx_valid until rxd high; rst_n pulse mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_t;

   localparam int unsigned OVERSAMPLE_DFLT = 16;
   localparam int unsigned DATA_BITS_MIN   = 5;
   localparam int unsigned DATA_BITS_MAX   = 8;

   // Index of the last data bit for a requested width, clamped to 5..8 bits.
   function automatic logic [2:0] last_bit_idx(input logic [3:0] bits);
      if (bits < 4'(DATA_BITS_MIN))
         return 3'(DATA_BITS_MIN - 1);
      else if (bits > 4'(DATA_BITS_MAX))
         return 3'(DATA_BITS_MAX - 1);
      else
         return 3'(bits - 4'd1);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rxd metastability synchronizer (idle-high reset) with a falling-edge pulse.
module uart_rx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_rxd,
   output logic o_rxd,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_sync <= '1;
      else
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
   end

   assign o_rxd  = r_sync[SYNC_STAGES-1];
   // Edge taken across the last two stages so the FSM reacts SYNC_STAGES clks after rxd.
   assign o_fall = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES-2];

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: deframes start/data/parity/stop and holds one char with status.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DFLT,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       tick_16x,
   output logic       enable_baud,
   input  logic [3:0] data_bits,
   input  logic       parity_en,
   input  logic       parity_even,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_read,
   output logic       parity_err,
   output logic       framing_err,
   output logic       break_det,
   output logic       overrun_err,
   output logic       rx_busy
);

   localparam logic [3:0] SAMPLE_CNT = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] WRAP_CNT   = 4'(OVERSAMPLE - 1);

   logic      w_rxd;
   logic      w_fall;
   rx_state_t r_state;
   rx_state_t w_next;

   logic [3:0] r_cnt;
   logic [2:0] r_idx;
   logic [2:0] r_last_idx;
   logic       r_par_en;
   logic       r_par_even;
   logic [7:0] r_shift;
   logic       r_any_one;
   logic       r_par_acc;
   logic       r_complete;
   logic       r_stop_bit;
   logic       r_brk;

   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_parity_err;
   logic       r_framing_err;
   logic       r_break_det;
   logic       r_overrun_err;
   logic       r_enable_baud;

   logic w_in_frame;
   logic w_sample;
   logic w_break;
   logic w_perr;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_rxd  (rxd),
      .o_rxd  (w_rxd),
      .o_fall (w_fall)
   );

   assign w_in_frame = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
   assign w_sample   = w_in_frame && tick_16x && (r_cnt == SAMPLE_CNT);
   assign w_break    = ~r_any_one & ~w_rxd;
   assign w_perr     = r_par_en & (r_par_even ? r_par_acc : ~r_par_acc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_fall) w_next = START;
         START:    if (w_sample) w_next = w_rxd ? IDLE : DATA;
         DATA:     if (w_sample && (r_idx == r_last_idx)) w_next = r_par_en ? PARITY : STOP;
         PARITY:   if (w_sample) w_next = STOP;
         STOP:     if (w_sample) w_next = w_break ? BRK_WAIT : IDLE;
         BRK_WAIT: if (w_rxd) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_idx         <= '0;
         r_last_idx    <= '0;
         r_par_en      <= 1'b0;
         r_par_even    <= 1'b0;
         r_shift       <= '0;
         r_any_one     <= 1'b0;
         r_par_acc     <= 1'b0;
         r_complete    <= 1'b0;
         r_stop_bit    <= 1'b0;
         r_brk         <= 1'b0;
         r_rx_data     <= '0;
         r_rx_valid    <= 1'b0;
         r_parity_err  <= 1'b0;
         r_framing_err <= 1'b0;
         r_break_det   <= 1'b0;
         r_overrun_err <= 1'b0;
         r_enable_baud <= 1'b0;
      end else begin
         r_complete <= 1'b0;
         if (w_in_frame && tick_16x)
            r_cnt <= (r_cnt == WRAP_CNT) ? '0 : r_cnt + 4'd1;

         if (w_sample) begin
            case (r_state)
               START: if (w_rxd) r_enable_baud <= 1'b0;
               DATA: begin
                  r_shift[r_idx] <= w_rxd;
                  r_idx          <= r_idx + 3'd1;
                  r_any_one      <= r_any_one | w_rxd;
                  r_par_acc      <= r_par_acc ^ w_rxd;
               end
               PARITY: begin
                  r_any_one <= r_any_one | w_rxd;
                  r_par_acc <= r_par_acc ^ w_rxd;
               end
               STOP: begin
                  r_complete <= 1'b1;
                  r_stop_bit <= w_rxd;
                  r_brk      <= w_break;
               end
               default: ;
            endcase
         end

         // Delivery runs one clk after the stop sample, when the FSM is already back in IDLE/BRK_WAIT.
         if (r_complete) begin
            r_enable_baud <= 1'b0;
            if (!r_rx_valid || rx_read) begin
               r_rx_data     <= r_brk ? '0 : r_shift;
               r_parity_err  <= w_perr;
               r_framing_err <= ~r_stop_bit;
               r_break_det   <= r_brk;
               r_rx_valid    <= 1'b1;
               r_overrun_err <= 1'b0;
            end else begin
               r_overrun_err <= 1'b1;
            end
         end else if (rx_read) begin
            r_rx_valid    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_break_det   <= 1'b0;
            r_overrun_err <= 1'b0;
         end

         if ((r_state == IDLE) && w_fall) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_last_idx    <= last_bit_idx(data_bits);
            r_par_en      <= parity_en;
            r_par_even    <= parity_even;
            r_shift       <= '0;
            r_any_one     <= 1'b0;
            r_par_acc     <= 1'b0;
            r_enable_baud <= 1'b1;
         end
      end
   end

   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign parity_err  = r_parity_err;
   assign framing_err = r_framing_err;
   assign break_det   = r_break_det;
   assign overrun_err = r_overrun_err;
   assign enable_baud = r_enable_baud;
   assign rx_busy     = (r_state != IDLE);

endmodule
